// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: loads 16 words, then streams W[0..63]
// from a 16-word sliding window with on-the-fly sigma expansion.
module sha256_msg_scheduler #(
  parameter int DATA_W    = 32,
  parameter int ROUNDS    = 64,
  parameter int BLK_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_w,
  output logic [5:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(BLK_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_WORDS - 1);
  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [5:0] t;
  logic [DATA_W-1:0] window [BLK_WORDS];
  logic [DATA_W-1:0] w_new;
  logic in_fire, out_fire;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign w_new    = sig1(window[14]) + window[9]
                  + sig0(window[1]) + window[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == CNT_LAST) state_nx = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && t == T_LAST) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  assign out_w    = out_valid ? window[0] : '0;
  assign out_idx  = t;
  assign out_last = out_valid && (t == T_LAST);

  // Window always holds W[t..t+15]; slot 15 takes the next expanded word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      t   <= '0;
      for (int i = 0; i < BLK_WORDS; i++) window[i] <= '0;
    end else begin
      if (in_fire) begin
        window[cnt] <= in_data;
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          t   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (out_fire) begin
        for (int i = 0; i < BLK_WORDS - 1; i++) window[i] <= window[i+1];
        window[BLK_WORDS-1] <= w_new;
        t <= (t == T_LAST) ? 6'd0 : t + 6'd1;
      end
    end
  end

endmodule

// File: doc/sha256_msg_scheduler.md
Name: sha256_msg_scheduler

Overview:
- Upstream feeder for the SHA-256 round core; produces the 64-entry message schedule W[0..63] for one 512-bit block.
- Accepts 16 message words serially on a 32-bit valid/ready input.
- Emits one W[t] per accepted output handshake, in order, for the round core's per-round word input.
- Uses a 16-word sliding window with on-the-fly sigma expansion; there is no 64-entry storage.

Parameters:
- DATA_W, 32, word width; fixed by SHA-256, must not be overridden.
- ROUNDS, 64, number of schedule words emitted per block.
- BLK_WORDS, 16, number of message words loaded per block.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; single clock domain.
- in_data  input  32  message word, big-endian word order, M[0] first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  scheduler accepts a word this cycle.
- out_w  output  32  current schedule word W[t].
- out_idx  output  6  round index t of out_w.
- out_valid  output  1  out_w/out_idx valid.
- out_ready  input  1  round core consumes out_w this cycle.
- out_last  output  1  high with out_valid when t = ROUNDS-1.
- busy  output  1  high in EMIT state.

Behaviour:
- Reset (async, active-high):
  - state=LOAD; load counter=0; t=0; window cleared to 0.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_w=0, out_idx=0.
- Reset asserted mid-block abandons the block with no partial output. Emission restarts only after 16 new words are loaded.
- States: LOAD, EMIT.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, in_data is written to window[cnt] and cnt increments.
  - On the 16th accept (cnt==15): cnt→0, t→0, next state EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored and words presented are not consumed.
  - out_valid=1, out_w=window[0], out_idx=t, out_last=(t==63), busy=1.
- Latency: W[0] appears on out_w the cycle after the 16th input handshake.
- On out_valid&&out_ready:
  - window[i]←window[i+1] for i=0..14.
  - window[15]←σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32 (carries beyond bit 31 discarded).
  - t increments.
  - Invariant: window holds W[t..t+15]. The expansion is computed every handshake, including t<16.
- Sigma functions:
  - σ0(x)=ROTR7(x)^ROTR18(x)^SHR3(x).
  - σ1(x)=ROTR17(x)^ROTR19(x)^SHR10(x).
- Backpressure: with out_ready=0, out_w, out_idx and out_last hold stable and the window does not shift, for any number of cycles.
- End of block: the handshake at t=63 returns the scheduler to LOAD.
  - Next cycle: out_valid=0, out_last=0, busy=0, in_ready=1.
  - t wraps to 0; there is no W[64].
- No simultaneous load/emit; the next block can be loaded only after W[63] is consumed.
- Output timing: all outputs are registered or decoded from registered state only; no combinational in→out path. in_ready depends only on state.

Test Plan:
- Reset then 16 words all 0x00000000 with out_ready=1:
  - out_valid rises the cycle after the 16th accept.
  - 64 words all 0x00000000 with out_idx 0..63.
  - out_last only at idx 63; in_ready=1 the cycle after.
- Words M[0..14]=0, M[15]=0x00000001:
  - W[15]=0x00000001, W[16]=0x00000000, W[17]=0x0000A000.
- Padded "abc" block (M[0]=0x61626380, M[1..14]=0, M[15]=0x00000018):
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000.
  - W[18..63] match the software reference model.
- Backpressure: toggle out_ready randomly (including 10-cycle stalls) during the abc block:
  - The emitted sequence is identical to the no-stall case.
  - out_w is stable while out_ready=0.
  - Exactly 64 handshakes.
- Load gaps and ignored input:
  - in_valid deasserted between words: only valid handshakes count.
  - in_valid held high during EMIT: in_ready=0, no word consumed, no corruption.
- Reset mid-operation:
  - Assert reset during LOAD (after 7 words) and again during EMIT at t=30.
  - Outputs go to reset values immediately (asynchronously).
  - A subsequent full abc load yields the correct W[0..63].
